// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and constants for the LFSR sequencing controller.
package lfsr_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam logic [7:0] SEED_DEFAULT = 8'h01;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // An all-zero seed would freeze the LFSR, so it is replaced by the default.
    function automatic logic [7:0] fix_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? SEED_DEFAULT : seed;
    endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Board-side inputs and LFSR-side outputs of the sequencing controller.
interface lfsr_seq_ctrl_if
    import lfsr_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic               i_btn_load;
    logic               i_btn_step;
    logic               i_run;
    logic [7:0]         i_seed;
    logic               o_lfsr_load;
    logic [7:0]         o_seed;
    logic               o_lfsr_step;
    logic [CNT_W-1:0]   o_step_cnt;
    logic [STATE_W-1:0] o_state;
    logic               o_seed_err;

    modport master (
        input  i_btn_load, i_btn_step, i_run, i_seed,
        output o_lfsr_load, o_seed, o_lfsr_step, o_step_cnt, o_state, o_seed_err
    );

    modport slave (
        output i_btn_load, i_btn_step, i_run, i_seed,
        input  o_lfsr_load, o_seed, o_lfsr_step, o_step_cnt, o_state, o_seed_err
    );

endinterface

// File: rtl/lfsr_seq_ctrl_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debounce, rising-edge press pulse.
module btn_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;

    // The counter only runs while the synchronized input disagrees with the debounced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CNT - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Turns debounced buttons and the run switch into single-cycle load/step commands for the LFSR.
module lfsr_seq_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int DEB_CNT = 1_000_000,
    parameter int RUN_DIV = 25_000_000,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    lfsr_seq_ctrl_if.master bus
);

    localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    state_t           r_state;
    logic [7:0]       r_seed;
    logic [CNT_W-1:0] r_step_cnt;
    logic [PW-1:0]    r_presc;
    logic             r_load;
    logic             r_step;
    logic             r_seed_err;
    logic             r_run_s1;
    logic             r_run_s2;
    logic             w_load_ev;
    logic             w_step_ev;
    logic             w_go_load;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_load (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.i_btn_load),
        .o_press (w_load_ev)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_step (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.i_btn_step),
        .o_press (w_step_ev)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
        end else begin
            r_run_s1 <= bus.i_run;
            r_run_s2 <= r_run_s1;
        end
    end

    // A load is honoured from IDLE and RUN only; it always beats a simultaneous step.
    assign w_go_load = w_load_ev && (r_state == ST_IDLE || r_state == ST_RUN);

    // Pulses are registered together with the state so they appear in the LOAD/STEP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_seed     <= SEED_DEFAULT;
            r_step_cnt <= '0;
            r_presc    <= '0;
            r_load     <= 1'b0;
            r_step     <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_step <= 1'b0;
            if (w_go_load) begin
                r_state    <= ST_LOAD;
                r_load     <= 1'b1;
                r_seed     <= fix_seed(bus.i_seed);
                r_seed_err <= (bus.i_seed == 8'h00);
                r_step_cnt <= '0;
                r_presc    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_step_ev) begin
                            r_state    <= ST_STEP;
                            r_step     <= 1'b1;
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end else if (r_run_s2) begin
                            r_state <= ST_RUN;
                            r_presc <= '0;
                        end
                    end
                    ST_LOAD, ST_STEP: begin
                        r_state <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (!r_run_s2) begin
                            r_state <= ST_IDLE;
                            r_presc <= '0;
                        end else if (r_presc == PW'(RUN_DIV - 1)) begin
                            r_presc    <= '0;
                            r_step     <= 1'b1;
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_lfsr_load = r_load;
    assign bus.o_lfsr_step = r_step;
    assign bus.o_seed      = r_seed;
    assign bus.o_step_cnt  = r_step_cnt;
    assign bus.o_state     = r_state;
    assign bus.o_seed_err  = r_seed_err;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a cycle-level reference model built from input history.
module tb_lfsr_seq_ctrl;

    localparam int DEB  = 4;
    localparam int RDIV = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   failed = 0;
    int   loadPulses = 0;
    int   stepPulses = 0;
    logic started = 1'b0;

    lfsr_seq_ctrl_if #(.CNT_W(8)) bus ();

    lfsr_seq_ctrl #(.DEB_CNT(DEB), .RUN_DIV(RDIV), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Model: raw input histories (bit 0 = newest edge sample), settled button levels, mode and outputs.
    logic [7:0] hL = '0, hS = '0, hR = '0;
    logic       debL = 1'b0, debLq = 1'b0, debS = 1'b0, debSq = 1'b0;
    int         mMode = 0;
    int         runCycles = 0;
    logic [7:0] mSeed = 8'h01;
    logic [7:0] mCnt = 8'h00;
    logic       mErr = 1'b0, mLoad = 1'b0, mStep = 1'b0;

    // A level settles once the last DEB synchronized samples all agree.
    function automatic logic settle(input logic [7:0] h, input logic cur);
        for (int i = 2; i <= DEB; i++)
            if (h[i] != h[1]) return cur;
        return h[1];
    endfunction

    task automatic modelReset();
        hL = '0; hS = '0; hR = '0;
        debL = 1'b0; debLq = 1'b0; debS = 1'b0; debSq = 1'b0;
        mMode = 0; runCycles = 0;
        mSeed = 8'h01; mCnt = 8'h00; mErr = 1'b0; mLoad = 1'b0; mStep = 1'b0;
    endtask

    task automatic modelStep();
        logic pL, pS, runNow;
        pL = debL & ~debLq;
        pS = debS & ~debSq;
        runNow = hR[1];
        mLoad = 1'b0;
        mStep = 1'b0;
        if (pL && (mMode == 0 || mMode == 3)) begin
            mMode = 1;
            mLoad = 1'b1;
            mSeed = (bus.i_seed == 8'h00) ? 8'h01 : bus.i_seed;
            mErr  = (bus.i_seed == 8'h00);
            mCnt  = 8'h00;
        end else if (mMode == 0 && pS) begin
            mMode = 2;
            mStep = 1'b1;
            mCnt  = mCnt + 8'd1;
        end else if (mMode == 0 && runNow) begin
            mMode = 3;
            runCycles = 0;
        end else if (mMode == 1 || mMode == 2) begin
            mMode = 0;
        end else if (mMode == 3) begin
            if (!runNow) begin
                mMode = 0;
            end else begin
                runCycles++;
                if (runCycles % RDIV == 0) begin
                    mStep = 1'b1;
                    mCnt  = mCnt + 8'd1;
                end
            end
        end
        debLq = debL;
        debL  = settle(hL, debL);
        debSq = debS;
        debS  = settle(hS, debS);
        hL = {hL[6:0], bus.i_btn_load};
        hS = {hS[6:0], bus.i_btn_step};
        hR = {hR[6:0], bus.i_run};
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) modelReset();
        else      modelStep();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            loadPulses += int'(bus.o_lfsr_load);
            stepPulses += int'(bus.o_lfsr_step);
            compared++;
            if (bus.o_state !== mMode[1:0] || bus.o_seed !== mSeed || bus.o_step_cnt !== mCnt ||
                bus.o_lfsr_load !== mLoad || bus.o_lfsr_step !== mStep || bus.o_seed_err !== mErr ||
                (bus.o_lfsr_load && bus.o_lfsr_step)) begin
                failed++;
                $display("[TB] FAIL model t=%0t: got st=%0d seed=%02h cnt=%0d ld=%b stp=%b err=%b expected st=%0d seed=%02h cnt=%0d ld=%b stp=%b err=%b",
                         $time, bus.o_state, bus.o_seed, bus.o_step_cnt, bus.o_lfsr_load,
                         bus.o_lfsr_step, bus.o_seed_err, mMode[1:0], mSeed, mCnt, mLoad, mStep, mErr);
            end
        end
    end

    task automatic applyStimulus(input logic ld, input logic st, input logic run,
                                 input logic [7:0] seed, input int cycles);
        bus.i_btn_load = ld;
        bus.i_btn_step = st;
        bus.i_run      = run;
        bus.i_seed     = seed;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " state"}, 32'(bus.o_state), 32'd0);
        checkOutput({tag, " seed"}, 32'(bus.o_seed), 32'h01);
        checkOutput({tag, " cnt"}, 32'(bus.o_step_cnt), 32'd0);
        checkOutput({tag, " load"}, 32'(bus.o_lfsr_load), 32'd0);
        checkOutput({tag, " step"}, 32'(bus.o_lfsr_step), 32'd0);
        checkOutput({tag, " err"}, 32'(bus.o_seed_err), 32'd0);
    endtask

    initial begin
        int ldBase, stBase;
        bit found;
        bus.i_btn_load = 1'b0;
        bus.i_btn_step = 1'b0;
        bus.i_run      = 1'b0;
        bus.i_seed     = 8'h00;
        #1 rst = 1'b0;
        started = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 3);
        checkResetValues("reset");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 2);

        $display("[TB] bouncing step button then a clean hold");
        ldBase = loadPulses; stBase = stepPulses;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 2);
            applyStimulus(0, 0, 0, 8'h00, 2);
        end
        checkOutput("bounce no step", 32'(stepPulses - stBase), 32'd0);
        applyStimulus(0, 1, 0, 8'h00, 10);
        applyStimulus(0, 0, 0, 8'h00, 10);
        checkOutput("held step pulses", 32'(stepPulses - stBase), 32'd1);
        checkOutput("held step cnt", 32'(bus.o_step_cnt), 32'd1);
        checkOutput("held step no load", 32'(loadPulses - ldBase), 32'd0);

        $display("[TB] seed loads");
        ldBase = loadPulses;
        applyStimulus(0, 0, 0, 8'hA5, 2);
        applyStimulus(1, 0, 0, 8'hA5, 8);
        applyStimulus(0, 0, 0, 8'hA5, 10);
        checkOutput("load A5 pulses", 32'(loadPulses - ldBase), 32'd1);
        checkOutput("load A5 seed", 32'(bus.o_seed), 32'hA5);
        checkOutput("load A5 err", 32'(bus.o_seed_err), 32'd0);
        checkOutput("load A5 cnt", 32'(bus.o_step_cnt), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 2);
        applyStimulus(1, 0, 0, 8'h00, 8);
        applyStimulus(0, 0, 0, 8'h00, 10);
        checkOutput("load 00 pulses", 32'(loadPulses - ldBase), 32'd2);
        checkOutput("load 00 seed", 32'(bus.o_seed), 32'h01);
        checkOutput("load 00 err", 32'(bus.o_seed_err), 32'd1);

        $display("[TB] run mode for 22 synchronized cycles");
        stBase = stepPulses;
        applyStimulus(0, 0, 1, 8'h00, 22);
        applyStimulus(0, 0, 0, 8'h00, 10);
        checkOutput("run pulses", 32'(stepPulses - stBase), 32'd4);
        checkOutput("run cnt", 32'(bus.o_step_cnt), 32'd4);
        checkOutput("run exit state", 32'(bus.o_state), 32'd0);

        $display("[TB] simultaneous load and step");
        ldBase = loadPulses; stBase = stepPulses;
        applyStimulus(1, 1, 0, 8'h3C, 8);
        applyStimulus(0, 0, 0, 8'h3C, 10);
        checkOutput("both load pulses", 32'(loadPulses - ldBase), 32'd1);
        checkOutput("both step pulses", 32'(stepPulses - stBase), 32'd0);
        checkOutput("both seed", 32'(bus.o_seed), 32'h3C);
        checkOutput("both err", 32'(bus.o_seed_err), 32'd0);
        checkOutput("both cnt", 32'(bus.o_step_cnt), 32'd0);

        $display("[TB] step counter wrap");
        stBase = stepPulses;
        for (int i = 0; i < 255; i++) begin
            applyStimulus(0, 1, 0, 8'h3C, 6);
            applyStimulus(0, 0, 0, 8'h3C, 6);
        end
        checkOutput("cnt 255", 32'(bus.o_step_cnt), 32'hFF);
        applyStimulus(0, 1, 0, 8'h3C, 6);
        applyStimulus(0, 0, 0, 8'h3C, 6);
        checkOutput("cnt wrap", 32'(bus.o_step_cnt), 32'd0);
        checkOutput("wrap pulses", 32'(stepPulses - stBase), 32'd256);
        applyStimulus(0, 1, 0, 8'h3C, 6);
        applyStimulus(0, 0, 0, 8'h3C, 6);
        checkOutput("cnt after wrap", 32'(bus.o_step_cnt), 32'd1);

        $display("[TB] reset in the middle of RUN");
        found = 1'b0;
        applyStimulus(0, 0, 1, 8'h3C, 1);
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.o_state == 2'd3) found = 1'b1;
            else applyStimulus(0, 0, 1, 8'h3C, 1);
        end
        checkOutput("run entered", 32'(found), 32'd1);
        applyStimulus(0, 0, 1, 8'h3C, 3);
        rst = 1'b0;
        bus.i_run = 1'b0;
        #1;
        checkResetValues("midrun");
        applyStimulus(0, 0, 0, 8'h3C, 3);
        rst = 1'b1;
        ldBase = loadPulses; stBase = stepPulses;
        applyStimulus(0, 0, 0, 8'h3C, 12);
        checkOutput("post reset step", 32'(stepPulses - stBase), 32'd0);
        checkOutput("post reset load", 32'(loadPulses - ldBase), 32'd0);
        checkOutput("post reset state", 32'(bus.o_state), 32'd0);

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
